// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beat counter must hold 0..MAX_BURST-1; sized one larger for a safe margin.
    function automatic int cnt_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above rr_ptr, with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    // Rotating a doubled vector puts rr_ptr at bit 0, so a plain LSB-first search wraps.
    assign rot = NUM_REQ'({req, req} >> rr_ptr);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IDX_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            idx = IDX_W'(sum - (IDX_W + 1)'(NUM_REQ));
        end else begin
            idx = IDX_W'(sum);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready streams.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_nx;
    logic [IDX_W-1:0]       grant_id_nx;
    logic [CNT_W-1:0]       beat_cnt, beat_cnt_nx;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   sel_valid;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
            grant_id <= grant_id_nx;
        end
    end

    assign grant_valid = (state == GRANT);

    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        grant_id_nx = grant_id;
        req_ready   = '0;
        fifo_en     = 1'b0;
        fifo_data   = '0;
        xfer        = 1'b0;
        sel_valid   = 1'b0;
        sel_data    = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_id_nx = pick_idx;
                    beat_cnt_nx = '0;
                    state_nx    = GRANT;
                end
            end
            GRANT: begin
                xfer = sel_valid & ~fifo_full;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_id == IDX_W'(i)) & ~fifo_full;
                end
                fifo_en   = xfer;
                fifo_data = xfer ? sel_data : '0;
                // Yield on burst end, last FIFO slot consumed, or an idle requester; the word still goes out.
                if ((xfer && ((beat_cnt == LAST_BEAT) || fifo_almost_full)) || !sel_valid) begin
                    state_nx    = IDLE;
                    beat_cnt_nx = '0;
                    rr_ptr_nx   = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
                end else if (xfer) begin
                    beat_cnt_nx = beat_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
